// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports, one write port and a
// per-register pending-write scoreboard. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy1_o,
    input  logic              re2_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              busy2_o,
    input  logic              issue_i,
    input  logic [AW-1:0]     issue_addr_i,
    output logic [AW:0]       pend_cnt_o
);

    // Read interface: no handshake. Decode presents re/raddr and samples rdata/busy in the
    // same cycle; busy=1 means the operand is not yet valid and decode must hold.

    logic [DATA_W-1:0] regs_q [1:REG_NUM-1];
    logic [DATA_W-1:0] regs_d [1:REG_NUM-1];
    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [AW:0]        pend_cnt_q, pend_cnt_d;

    logic wr_valid;
    logic iss_valid;

    assign wr_valid  = we_i && (waddr_i != '0);
    assign iss_valid = issue_i && (issue_addr_i != '0);

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (wr_valid && (waddr_i == AW'(i))) begin
                regs_d[i]    = wdata_i;
                pending_d[i] = 1'b0;
            end
            // Applied after the clear so a newer in-flight producer keeps the bit set.
            if (iss_valid && (issue_addr_i == AW'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            pend_cnt_d = pend_cnt_d + (AW+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;

    logic bypass1, bypass2;

`ifdef REGFILE_BYPASS_EN
    assign bypass1 = wr_valid && (waddr_i == raddr1_i);
    assign bypass2 = wr_valid && (waddr_i == raddr2_i);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    logic [DATA_W-1:0] stored1, stored2;

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            if (raddr1_i == AW'(i)) stored1 = regs_q[i];
            if (raddr2_i == AW'(i)) stored2 = regs_q[i];
        end
    end

    logic rd1_act, rd2_act;

    assign rd1_act = !rst && re1_i && (raddr1_i != '0);
    assign rd2_act = !rst && re2_i && (raddr2_i != '0);

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (rd1_act) rdata1_o = bypass1 ? wdata_i : stored1;
        if (rd2_act) rdata2_o = bypass2 ? wdata_i : stored2;
    end

    assign busy1_o = rd1_act && pending_q[raddr1_i] && !bypass1;
    assign busy2_o = rd2_act && pending_q[raddr2_i] && !bypass2;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        busy1_o, busy2_o;
  logic        issue_i;
  logic [4:0]  issue_addr_i;
  logic [5:0]  pend_cnt_o;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o), .busy1_o(busy1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o), .busy2_o(busy2_o),
    .issue_i(issue_i), .issue_addr_i(issue_addr_i), .pend_cnt_o(pend_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  localparam int S_RD1 = 0, S_RD2 = 1, S_BZ1 = 2, S_BZ2 = 3, S_CNT = 4;
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic expect_out(input int sel, input logic [31:0] val, input string name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  // Outputs are combinational/registered and present every cycle; the monitor samples
  // on the falling edge whatever expectations the stimulus queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, a;
      int s;
      string nm;
      e  = exp_q.pop_front();
      s  = sel_q.pop_front();
      nm = name_q.pop_front();
      case (s)
        S_RD1:   a = rdata1_o;
        S_RD2:   a = rdata2_o;
        S_BZ1:   a = {31'd0, busy1_o};
        S_BZ2:   a = {31'd0, busy2_o};
        default: a = {26'd0, pend_cnt_o};
      endcase
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, a, e);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
    we_i = we; waddr_i = a; wdata_i = d;
  endtask

  task automatic drive_iss(input logic iss, input logic [4:0] a);
    issue_i = iss; issue_addr_i = a;
  endtask

  task automatic drive_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
  endtask

  initial begin
    rst = 1'b1;
    drive_wr(0, 0, 0);
    drive_iss(0, 0);
    drive_rd(1, 5, 1, 7);
    repeat (2) @(posedge clk);
    #1;
    expect_out(S_RD1, 0, "reset_rdata1");
    expect_out(S_RD2, 0, "reset_rdata2");
    expect_out(S_BZ1, 0, "reset_busy1");
    expect_out(S_CNT, 0, "reset_pend_cnt");
    step();
    rst = 1'b0;

    // write r5 = 0x1234 while reading it
    drive_wr(1, 5, 32'h0000_1234);
    expect_out(S_RD1, BYP ? 32'h1234 : 32'h0, "r5_same_cycle");
    step();
    drive_wr(0, 0, 0);
    expect_out(S_RD1, 32'h1234, "r5_after_write");

    // register 0: write and issue ignored
    step();
    drive_wr(1, 0, 32'hFFFF_FFFF);
    drive_iss(1, 0);
    drive_rd(1, 0, 1, 0);
    expect_out(S_RD1, 0, "r0_read_during_write");
    step();
    drive_wr(0, 0, 0);
    drive_iss(0, 0);
    expect_out(S_RD1, 0, "r0_rdata1");
    expect_out(S_RD2, 0, "r0_rdata2");
    expect_out(S_BZ1, 0, "r0_busy1");
    expect_out(S_CNT, 0, "r0_issue_cnt");

    // write/read same cycle on port 2
    step();
    drive_wr(1, 7, 32'h1111_1111);
    step();
    drive_wr(1, 7, 32'hDEAD_BEEF);
    drive_rd(0, 0, 1, 7);
    expect_out(S_RD2, BYP ? 32'hDEAD_BEEF : 32'h1111_1111, "r7_same_cycle");
    step();
    drive_wr(0, 0, 0);
    expect_out(S_RD2, 32'hDEAD_BEEF, "r7_next_cycle");

    // scoreboard: issue r3, then write it back
    step();
    drive_iss(1, 3);
    drive_rd(1, 3, 0, 0);
    expect_out(S_BZ1, 0, "r3_busy_issue_cycle");
    expect_out(S_CNT, 0, "r3_cnt_issue_cycle");
    step();
    drive_iss(0, 0);
    expect_out(S_BZ1, 1, "r3_busy_after_issue");
    expect_out(S_CNT, 1, "r3_cnt_after_issue");
    step();
    drive_wr(1, 3, 32'h55);
    expect_out(S_BZ1, BYP ? 32'd0 : 32'd1, "r3_busy_write_cycle");
    expect_out(S_RD1, BYP ? 32'h55 : 32'h0, "r3_rdata_write_cycle");
    expect_out(S_CNT, 1, "r3_cnt_write_cycle");
    step();
    drive_wr(0, 0, 0);
    expect_out(S_BZ1, 0, "r3_busy_after_write");
    expect_out(S_CNT, 0, "r3_cnt_after_write");
    expect_out(S_RD1, 32'h55, "r3_rdata_after_write");

    // disabled read of a pending register
    step();
    drive_iss(1, 3);
    step();
    drive_iss(0, 0);
    drive_rd(0, 3, 0, 0);
    expect_out(S_RD1, 0, "disabled_rdata1");
    expect_out(S_BZ1, 0, "disabled_busy1");
    expect_out(S_CNT, 1, "disabled_cnt");
    step();
    drive_rd(1, 3, 0, 0);
    expect_out(S_RD1, 32'h55, "reenabled_rdata1");
    expect_out(S_BZ1, 1, "reenabled_busy1");

    // simultaneous issue and write to r9: set wins, data lands
    step();
    drive_iss(1, 9);
    drive_wr(1, 9, 32'h10);
    step();
    drive_wr(0, 0, 0);
    drive_rd(1, 9, 1, 5);
    expect_out(S_RD1, 32'h10, "r9_data");
    expect_out(S_BZ1, 1, "r9_busy");
    expect_out(S_CNT, 2, "r9_cnt");

    // issue already-pending r9 again: no saturation, count unchanged
    step();
    drive_iss(0, 0);
    expect_out(S_CNT, 2, "r9_reissue_cnt");
    expect_out(S_RD2, 32'h1234, "r5_before_reset");

    // asynchronous reset mid-cycle, with a write held across the reset edge
    step();
    drive_rd(1, 5, 1, 9);
    drive_wr(1, 5, 32'hAAAA_AAAA);
    drive_iss(1, 11);
    rst = 1'b1;
    expect_out(S_RD1, 0, "rst_async_rdata1");
    expect_out(S_BZ2, 0, "rst_async_busy2");
    expect_out(S_CNT, 0, "rst_async_cnt");
    step();
    rst = 1'b0;
    drive_wr(0, 0, 0);
    drive_iss(0, 0);
    expect_out(S_RD1, 0, "r5_cleared");
    expect_out(S_BZ2, 0, "r9_pending_cleared");
    expect_out(S_CNT, 0, "cnt_after_reset");
    step();
    drive_rd(1, 11, 0, 0);
    expect_out(S_BZ1, 0, "discarded_issue_r11");

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

General-purpose register file for the five-stage MIPS core, the responder side of the decode stage's read interface. It holds 32 × 32-bit registers with `$0` hardwired to zero, and serves two combinational read ports to decode. It takes one write port from write-back and keeps a per-register pending-write scoreboard, so decode can detect that a source operand has not yet been produced.

## Interface
Parameters
- `REG_NUM`, 32: number of architectural registers. The width of `RegAddrBus` must equal log2(`REG_NUM`).
- `DATA_W`, 32: register width, matching `RegDataBus`.

Ports
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we_i`  in  1  write-back write enable.
- `waddr_i`  in  5  write-back destination register.
- `wdata_i`  in  32  write-back data.
- `re1_i` / `re2_i`  in  1  read enables from decode.
- `raddr1_i` / `raddr2_i`  in  5  read addresses from decode.
- `rdata1_o` / `rdata2_o`  out  32  read data, combinational.
- `busy1_o` / `busy2_o`  out  1  the addressed source has a pending, not-yet-written result.
- `issue_i`  in  1  decode issues an instruction that will write `issue_addr_i`.
- `issue_addr_i`  in  5  destination of the issued instruction.
- `pend_cnt_o`  out  6  registered count of pending registers, 0..31.

## Operation
- **Storage:** registers 1..31 are flops. Register 0 has no storage and always reads as `ZeroWord`.
- **Write:** on a rising edge with `we_i`=1 and `waddr_i`≠0, the register at `waddr_i` takes `wdata_i` and its pending bit clears. Writes to address 0 are ignored entirely.
- **Issue:** on a rising edge with `issue_i`=1 and `issue_addr_i`≠0, the pending bit at `issue_addr_i` sets. Issue to address 0 is ignored.
- **Simultaneous issue and write, same address:** the set wins, because a newer producer is in flight. The register data still takes `wdata_i`.
- **Read, per port n:** `rdata_n_o` follows the first matching rule.
  - `ZeroWord` if `rst`=1, or `re_n_i`=0, or `raddr_n_i`=0.
  - Otherwise, the bypass value, if bypass is compiled in and `we_i`=1 and `waddr_i`=`raddr_n_i`.
  - Otherwise, the stored register.
- **Busy:** `busy_n_o` = `re_n_i` & (`raddr_n_i`≠0) & pending[`raddr_n_i`] & ~bypass_hit_n. It is 0 while `rst`=1.
- **Pending count:** `pend_cnt_o` is the popcount of pending bits 1..31, registered. It reflects the bit vector after each edge.
- **Reset:** asserting `rst` asynchronously clears all registers to 0, all pending bits, and `pend_cnt_o`. `rst` asserted mid-operation discards any in-flight write or issue that edge.

## Timing
- **Read:** zero cycles, purely combinational from address, enable and (with bypass) the write port.
- **Write visibility:**
  - With bypass: the same cycle.
  - Without bypass: from the cycle after the write edge.
- **Issue → busy:** busy asserts from the cycle after the issue edge.
- **Write → busy deassert:**
  - With bypass: the same cycle the write is presented.
  - Without bypass: the cycle after the write edge.
- **`pend_cnt_o`:** changes one cycle after the causing issue/write edge.
- **Reset values:** `rdata1_o`=`rdata2_o`=0, `busy1_o`=`busy2_o`=0, `pend_cnt_o`=0.
- **Saturation:** none; 31 pending bits max. An issue to an already-pending register leaves the bit set and the count unchanged.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is present, as described above.
- Not defined: reads always return stored values, and the bypass term in busy is 0. Decode must then stall one extra cycle on a same-cycle write-back.

## Test plan
- **Reset:** assert `rst` mid-run after writing r5=0x1234 → r5 reads 0, `pend_cnt_o`=0, busy outputs 0 immediately, before any clock edge.
- **Register 0:** write r0=0xFFFFFFFF, then read r0 → `rdata1_o`=0. Issue to r0 → `pend_cnt_o` stays 0.
- **Write/read same cycle:** write r7=0xDEADBEEF while reading r7 on port 2.
  - With bypass: `rdata2_o`=0xDEADBEEF that cycle.
  - Without: old value that cycle, 0xDEADBEEF the next.
- **Scoreboard:** issue r3 → next cycle `busy1_o`=1 for raddr1=3 and `pend_cnt_o`=1. Write r3=0x55 → busy clears per the bypass rule, `pend_cnt_o`=0.
- **Simultaneous issue and write:** issue r9 and write r9=0x10 on the same edge → r9 reads 0x10, pending bit stays set, `busy1_o`=1.
- **Disabled read:** `re1_i`=0 with raddr1=3 pending and r3=0x55 → `rdata1_o`=0, `busy1_o`=0.
